// File: rtl/button_pkg.sv
// Shared edge-mode codes and counter sizing for the pushbutton conditioner.
// Optional auto-repeat is enabled with BUTTON_PULSE_AUTO_REPEAT_EN.
package button_pkg;

    localparam int unsigned EDGE_RISE = 0;
    localparam int unsigned EDGE_FALL = 1;
    localparam int unsigned EDGE_BOTH = 2;

    // Enough bits to hold 0..v-1 with one spare, never narrower than 1 bit.
    function automatic int unsigned cnt_width(input int unsigned v);
        return $clog2(v) + 1;
    endfunction

endpackage

// File: rtl/btn_channel.sv
// One pushbutton channel: synchroniser chain, debouncer, edge pulse and
// optional hold-to-repeat (BUTTON_PULSE_AUTO_REPEAT_EN).
module btn_channel
    import button_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned EDGE_MODE       = 0,
    parameter int unsigned HOLD_CYCLES     = 200,
    parameter int unsigned REPEAT_CYCLES   = 50
) (
    input  logic sp_clock,
    input  logic reset,
    input  logic btn_in,
    output logic btn_level,
    output logic btn_pulse
);

    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("SYNC_STAGES must be at least 2");
    end
    if (DEBOUNCE_CYCLES < 1 || HOLD_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_bad_cnt
        $error("DEBOUNCE_CYCLES, HOLD_CYCLES and REPEAT_CYCLES must be at least 1");
    end

    localparam int unsigned DbW = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [DbW-1:0] DbLast = DbW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [DbW-1:0]         db_cnt_q, db_cnt_d;
    logic                   level_q, level_d;
    logic                   pulse_q, pulse_d;
    logic                   s, rise, fall, edge_pulse, rpt_pulse;

    assign s = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d   = {sync_q[SYNC_STAGES-2:0], btn_in};
        level_d  = level_q;
        db_cnt_d = db_cnt_q;
        if (s == level_q) begin
            db_cnt_d = '0;
        end else if (db_cnt_q == DbLast) begin
            level_d  = s;
            db_cnt_d = '0;
        end else begin
            db_cnt_d = db_cnt_q + DbW'(1);
        end

        rise = level_d & ~level_q;
        fall = ~level_d & level_q;
        case (EDGE_MODE)
            EDGE_RISE: edge_pulse = rise;
            EDGE_FALL: edge_pulse = fall;
            default:   edge_pulse = rise | fall;
        endcase
        pulse_d = edge_pulse | rpt_pulse;
    end

`ifdef BUTTON_PULSE_AUTO_REPEAT_EN
    localparam int unsigned HoldSpan =
        (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int unsigned HoldW = cnt_width(HoldSpan);
    localparam logic [HoldW-1:0] HoldLast = HoldW'(HOLD_CYCLES - 1);
    localparam logic [HoldW-1:0] RptLast  = HoldW'(REPEAT_CYCLES - 1);

    logic [HoldW-1:0] hold_cnt_q, hold_cnt_d;
    logic             repeating_q, repeating_d;

    // Counter restarts on the press pulse; repeating_q selects the long first gap vs the period.
    always_comb begin
        hold_cnt_d  = hold_cnt_q;
        repeating_d = repeating_q;
        rpt_pulse   = 1'b0;
        if (EDGE_MODE != EDGE_FALL) begin
            if (!level_d || !level_q) begin
                hold_cnt_d  = '0;
                repeating_d = 1'b0;
            end else if (hold_cnt_q == (repeating_q ? RptLast : HoldLast)) begin
                rpt_pulse   = 1'b1;
                hold_cnt_d  = '0;
                repeating_d = 1'b1;
            end else begin
                hold_cnt_d = hold_cnt_q + HoldW'(1);
            end
        end
    end

    always_ff @(posedge sp_clock or posedge reset) begin
        if (reset) begin
            hold_cnt_q  <= '0;
            repeating_q <= 1'b0;
        end else begin
            hold_cnt_q  <= hold_cnt_d;
            repeating_q <= repeating_d;
        end
    end
`else
    assign rpt_pulse = 1'b0;
`endif

    always_ff @(posedge sp_clock or posedge reset) begin
        if (reset) begin
            sync_q   <= '0;
            db_cnt_q <= '0;
            level_q  <= 1'b0;
            pulse_q  <= 1'b0;
        end else begin
            sync_q   <= sync_d;
            db_cnt_q <= db_cnt_d;
            level_q  <= level_d;
            pulse_q  <= pulse_d;
        end
    end

    assign btn_level = level_q;
    assign btn_pulse = pulse_q;

endmodule

// File: rtl/button_pulse_ctrl.sv
// N-channel pushbutton conditioner: independent channels plus a combined pulse flag.
// Define BUTTON_PULSE_AUTO_REPEAT_EN to enable hold-to-repeat pulses.
module button_pulse_ctrl
    import button_pkg::*;
#(
    parameter int unsigned N_CH            = 5,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned EDGE_MODE       = EDGE_RISE,
    parameter int unsigned HOLD_CYCLES     = 200,
    parameter int unsigned REPEAT_CYCLES   = 50
) (
    input  logic            sp_clock,
    input  logic            reset,
    input  logic [N_CH-1:0] btn_in,
    output logic [N_CH-1:0] btn_level,
    output logic [N_CH-1:0] btn_pulse,
    output logic            any_pulse
);

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        btn_channel #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .EDGE_MODE      (EDGE_MODE),
            .HOLD_CYCLES    (HOLD_CYCLES),
            .REPEAT_CYCLES  (REPEAT_CYCLES)
        ) u_ch (
            .sp_clock (sp_clock),
            .reset    (reset),
            .btn_in   (btn_in[i]),
            .btn_level(btn_level[i]),
            .btn_pulse(btn_pulse[i])
        );
    end

    assign any_pulse = |btn_pulse;

endmodule
